// File: rtl/sram_word_initiator.sv
// sram_word_initiator: turns one 32-bit word request from the CPU load/store
// path into four sequential byte accesses on a byte-wide synchronous SRAM,
// then returns a single response. At most one request is ever outstanding.
module sram_word_initiator #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  localparam int W = 4 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [W-1:0]          req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [W-1:0]          rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  output logic                  sram_write_enable,
  input  logic [DATA_WIDTH-1:0] sram_read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state_q;
  // Counts edges since acceptance: 1..4 for writes, 1..5 for reads.
  logic [2:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [W-1:0]            wdata_q;
  logic [3:0]              be_q;
  // Bytes 0..2 of a read; byte 3 is merged straight into the response.
  logic [3*DATA_WIDTH-1:0] asm_q;

  logic                    rsp_valid_q;
  logic                    rsp_write_q;
  logic [W-1:0]            rsp_rdata_q;
  logic [ADDR_WIDTH-1:0]   sram_address_q;
  logic [DATA_WIDTH-1:0]   sram_write_data_q;
  logic                    sram_write_enable_q;

  // The request is word aligned, so the two low address bits carry no meaning.
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = &{1'b0, req_addr[1:0]};

  // Little-endian lane select: lane k is word bits [8k+7:8k].
  function automatic logic [DATA_WIDTH-1:0] lane_of(input logic [W-1:0] word,
                                                    input logic [1:0]   idx);
    lane_of = word[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Byte address within the captured aligned word; cannot carry out of it.
  function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic [ADDR_WIDTH-1:0] base,
                                                      input logic [1:0]            idx);
    byte_addr = {base[ADDR_WIDTH-1:2], idx};
  endfunction

  assign req_ready         = (state_q == IDLE);
  assign rsp_valid         = rsp_valid_q;
  assign rsp_write         = rsp_write_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign sram_address      = sram_address_q;
  assign sram_write_data   = sram_write_data_q;
  assign sram_write_enable = sram_write_enable_q;

  // Request/response FSM driving the registered SRAM and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      cnt_q               <= 3'd0;
      base_q              <= '0;
      wdata_q             <= '0;
      be_q                <= 4'b0000;
      asm_q               <= '0;
      rsp_valid_q         <= 1'b0;
      rsp_write_q         <= 1'b0;
      rsp_rdata_q         <= '0;
      sram_address_q      <= '0;
      sram_write_data_q   <= '0;
      sram_write_enable_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // Acceptance edge: capture everything and drive byte 0 right away.
            base_q         <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            wdata_q        <= req_wdata;
            be_q           <= req_be;
            cnt_q          <= 3'd1;
            sram_address_q <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (req_write) begin
              sram_write_data_q   <= req_wdata[DATA_WIDTH-1:0];
              sram_write_enable_q <= req_be[0];
              state_q             <= WRITE;
            end else begin
              sram_write_enable_q <= 1'b0;
              state_q             <= READ;
            end
          end else begin
            sram_write_enable_q <= 1'b0;
          end
        end

        WRITE: begin
          if (cnt_q == 3'd4) begin
            sram_write_enable_q <= 1'b0;
            rsp_valid_q         <= 1'b1;
            rsp_write_q         <= 1'b1;
            rsp_rdata_q         <= '0;
            cnt_q               <= 3'd0;
            state_q             <= RESP;
          end else begin
            // Disabled lanes still spend their cycle, keeping timing fixed.
            sram_address_q      <= byte_addr(base_q, cnt_q[1:0]);
            sram_write_data_q   <= lane_of(wdata_q, cnt_q[1:0]);
            sram_write_enable_q <= be_q[cnt_q[1:0]];
            cnt_q               <= cnt_q + 3'd1;
          end
        end

        READ: begin
          sram_write_enable_q <= 1'b0;
          if (cnt_q <= 3'd3) begin
            sram_address_q <= byte_addr(base_q, cnt_q[1:0]);
          end else begin
            sram_address_q <= sram_address_q;
          end
          // SRAM data for byte k arrives two edges after its address.
          case (cnt_q)
            3'd2: asm_q[DATA_WIDTH-1:0]              <= sram_read_data;
            3'd3: asm_q[2*DATA_WIDTH-1:DATA_WIDTH]   <= sram_read_data;
            3'd4: asm_q[3*DATA_WIDTH-1:2*DATA_WIDTH] <= sram_read_data;
            3'd5: begin
              rsp_rdata_q <= {sram_read_data, asm_q};
              rsp_valid_q <= 1'b1;
              rsp_write_q <= 1'b0;
              state_q     <= RESP;
            end
            default: asm_q <= asm_q;
          endcase
          if (cnt_q == 3'd5) begin
            cnt_q <= 3'd0;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end

        RESP: begin
          sram_write_enable_q <= 1'b0;
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end

        default: begin
          sram_write_enable_q <= 1'b0;
          rsp_valid_q         <= 1'b0;
          cnt_q               <= 3'd0;
          state_q             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_word_initiator.sv
// Self-checking bench for sram_word_initiator: a behavioural byte SRAM with
// 1-cycle registered reads, plus a word-level reference memory.
module tb_sram_word_initiator;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [9:0]  sram_address;
  logic [7:0]  sram_write_data;
  logic        sram_write_enable;
  logic [7:0]  sram_read_data;

  bit [7:0] mem     [1024];   // the SRAM contents
  bit [7:0] exp_mem [1024];   // reference model of what SRAM should hold

  int checks = 0;
  int errors = 0;

  sram_word_initiator #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_be            (req_be),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_write         (rsp_write),
    .rsp_rdata         (rsp_rdata),
    .sram_address      (sram_address),
    .sram_write_data   (sram_write_data),
    .sram_write_enable (sram_write_enable),
    .sram_read_data    (sram_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous SRAM: registered read, write on the edge.
  always @(posedge clk) begin
    if (sram_write_enable) mem[sram_address] <= sram_write_data;
    sram_read_data <= mem[sram_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction, entered and left at a negative clock edge.
  task automatic do_txn(input logic wr, input logic [9:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int stall, input bit hold_valid);
    logic [9:0]  base;
    logic [31:0] exp_rd;
    int          n;
    bit          seen;
    base = {addr[9:2], 2'b00};
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    rsp_ready = 1'($urandom_range(0, 1));
    exp_rd    = 32'd0;
    if (wr) begin
      for (int k = 0; k < 4; k++) if (be[k]) exp_mem[base + 10'(k)] = wd[8*k +: 8];
    end else begin
      for (int k = 0; k < 4; k++) exp_rd[8*k +: 8] = exp_mem[base + 10'(k)];
    end
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      if (n == 0) begin
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 10'($urandom);
        req_wdata = $urandom;
        req_be    = 4'($urandom);
      end
      if (n < 4) begin
        check("sram_addr", {22'd0, sram_address}, {22'd0, base + 10'(n)});
        check("sram_we", {31'd0, sram_write_enable}, {31'd0, wr & be[n]});
        if (wr && be[n]) check("sram_wdata", {24'd0, sram_write_data}, {24'd0, wd[8*n +: 8]});
      end else begin
        check("sram_we_off", {31'd0, sram_write_enable}, 32'd0);
      end
      if (rsp_valid) seen = 1'b1;
      else n++;
    end
    check("latency", n, wr ? 32'd4 : 32'd5);
    if (seen) begin
      check("rsp_write", {31'd0, rsp_write}, {31'd0, wr});
      check("rsp_rdata", rsp_rdata, exp_rd);
      for (int s = 0; s < stall; s++) begin
        rsp_ready = 1'b0;
        if (hold_valid) begin
          req_valid = 1'b1;
          req_write = 1'($urandom);
          req_addr  = 10'($urandom);
          req_wdata = $urandom;
        end
        @(negedge clk);
        check("stall_valid", {31'd0, rsp_valid}, 32'd1);
        check("stall_write", {31'd0, rsp_write}, {31'd0, wr});
        check("stall_rdata", rsp_rdata, exp_rd);
        check("stall_ready", {31'd0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rsp_drop", {31'd0, rsp_valid}, 32'd0);
      check("ready_after", {31'd0, req_ready}, 32'd1);
      rsp_ready = 1'($urandom_range(0, 1));
      if (!hold_valid) req_valid = 1'b0;
      if (wr) begin
        for (int k = 0; k < 4; k++)
          check("mem_byte", {24'd0, mem[base + 10'(k)]}, {24'd0, exp_mem[base + 10'(k)]});
      end
    end
  endtask

  initial begin
    logic [9:0] rbase;
    logic [7:0] old2;
    logic [7:0] old3;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 10'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_write", {31'd0, rsp_write}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_sram_addr", {22'd0, sram_address}, 32'd0);
    check("rst_sram_wdata", {24'd0, sram_write_data}, 32'd0);
    check("rst_sram_we", {31'd0, sram_write_enable}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full write, then read with non-zero low address bits.
    do_txn(1'b1, 10'h010, 32'hDDCCBBAA, 4'b1111, 0, 1'b0);
    do_txn(1'b0, 10'h013, 32'h0, 4'b0000, 0, 1'b0);
    check("read_word_const", rsp_rdata, 32'hDDCCBBAA);
    // Partial write lanes 0 and 2, read back.
    do_txn(1'b1, 10'h010, 32'h11223344, 4'b0101, 0, 1'b0);
    do_txn(1'b0, 10'h010, 32'h0, 4'b0000, 0, 1'b0);
    check("partial_word_const", rsp_rdata, 32'hDD22BB44);
    // Back-pressure with req_valid held high, then next request immediately.
    do_txn(1'b0, 10'h010, 32'h0, 4'b0000, 3, 1'b1);
    do_txn(1'b1, 10'h020, 32'hCAFEF00D, 4'b1111, 0, 1'b0);
    do_txn(1'b0, 10'h020, 32'h0, 4'b0000, 1, 1'b0);
    // Top word of the address space.
    do_txn(1'b1, 10'h3FE, 32'h5A6B7C8D, 4'b1111, 0, 1'b0);
    do_txn(1'b0, 10'h3FC, 32'h0, 4'b0000, 0, 1'b0);

    // Randomized traffic checked against the reference memory.
    for (int i = 0; i < 30; i++) begin
      do_txn(1'($urandom), 10'($urandom_range(0, 255)), $urandom, 4'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom));
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a write, after the second byte edge.
    rbase = 10'h200;
    old2  = exp_mem[rbase + 10'd2];
    old3  = exp_mem[rbase + 10'd3];
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = rbase;
    req_wdata = 32'hA1B2C3D4;
    req_be    = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_sram_we", {31'd0, sram_write_enable}, 32'd0);
    check("mid_rst_sram_addr", {22'd0, sram_address}, 32'd0);
    check("mid_rst_sram_wdata", {24'd0, sram_write_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_byte0", {24'd0, mem[rbase]}, 32'h000000D4);
    check("post_rst_byte2", {24'd0, mem[rbase + 10'd2]}, {24'd0, old2});
    check("post_rst_byte3", {24'd0, mem[rbase + 10'd3]}, {24'd0, old3});
    do_txn(1'b0, 10'h010, 32'h0, 4'b0000, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
